// File: rtl/arm_pkg.sv
// Shared LEGv8 definitions: datapath widths, the fetch FSM state type and the
// opcode constants that decode matches on.
package arm_pkg;

    localparam int WORD      = 64;
    localparam int INSTR_LEN = 32;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // 11-bit R/D-format opcodes, 6-bit B and 8-bit CB opcodes.
    localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
    localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
    localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
    localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
    localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
    localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;
    localparam logic [5:0]  OP_B    = 6'b00_0101;
    localparam logic [7:0]  OP_CBZ  = 8'b1011_0100;

endpackage

// File: rtl/i_mem.sv
// Instruction memory: synchronous loader write, combinational fetch read, no reset.
module i_mem #(
    parameter int DEPTH = 64,
    parameter int WIDTH = arm_pkg::INSTR_LEN,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    import arm_pkg::*;

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Loader write port; a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/i_fetch.sv
// LEGv8 instruction-fetch stage: PC/redirect logic, boot/run/halt FSM and the
// registered instruction, PC and valid handed to decode.
module i_fetch #(
    parameter int              WORD       = arm_pkg::WORD,
    parameter int              INSTR_LEN  = arm_pkg::INSTR_LEN,
    parameter int              IMEM_DEPTH = 64,
    parameter longint unsigned RESET_PC   = 64'd0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          stall,
    input  logic                          uncondbranch,
    input  logic                          branch,
    input  logic                          zero,
    input  logic [WORD-1:0]               branch_offset,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [INSTR_LEN-1:0]          imem_wdata,
    output logic [INSTR_LEN-1:0]          instruction_out,
    output logic [WORD-1:0]               pc_out,
    output logic                          valid,
    output logic                          halted
);
    import arm_pkg::*;

    localparam int             AW         = $clog2(IMEM_DEPTH);
    localparam logic [WORD-1:0] RESET_ADDR = WORD'(RESET_PC);
    localparam logic [WORD-1:0] IMEM_BYTES = WORD'(IMEM_DEPTH * 4);
    localparam logic [WORD-1:0] STEP       = WORD'(3'd4);

    fetch_state_t         state_r, state_nx_s;
    logic [WORD-1:0]      fetch_pc_r, fetch_pc_nx_s;
    logic [WORD-1:0]      pc_r, pc_nx_s;
    logic [INSTR_LEN-1:0] instr_r, instr_nx_s;
    logic                 valid_r, valid_nx_s;
    logic                 halted_r, halted_nx_s;

    logic                 pc_src_s;
    logic [WORD-1:0]      target_s, next_addr_s, fetch_addr_s;
    logic                 oor_s;
    logic                 mem_we_s;
    logic [INSTR_LEN-1:0] rdata_s;

    // A write coinciding with a reset edge is dropped.
    assign mem_we_s = imem_we & reset_n;

    i_mem #(
        .DEPTH (IMEM_DEPTH),
        .WIDTH (INSTR_LEN),
        .AW    (AW)
    ) u_i_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (imem_waddr),
        .wdata (imem_wdata),
        .raddr (fetch_addr_s[AW+1:2]),
        .rdata (rdata_s)
    );

    // Fetch address selection: redirect target or sequential PC, BOOT uses RESET_PC.
    always_comb begin
        pc_src_s = valid_r & (uncondbranch | (branch & zero));
        target_s = pc_r + (branch_offset << 2);
        if (pc_src_s) begin
            next_addr_s = target_s;
        end else begin
            next_addr_s = fetch_pc_r;
        end
        if (state_r == BOOT) begin
            fetch_addr_s = RESET_ADDR;
        end else begin
            fetch_addr_s = next_addr_s;
        end
        oor_s = (fetch_addr_s >= IMEM_BYTES);
    end

    // FSM next state and output-register next values; holding is the default.
    always_comb begin
        state_nx_s    = state_r;
        fetch_pc_nx_s = fetch_pc_r;
        pc_nx_s       = pc_r;
        instr_nx_s    = instr_r;
        valid_nx_s    = valid_r;
        halted_nx_s   = halted_r;
        case (state_r)
            BOOT, RUN: begin
                if ((state_r == RUN) && stall) begin
                    state_nx_s = state_r;
                end else if (oor_s) begin
                    state_nx_s  = HALT;
                    pc_nx_s     = fetch_addr_s;
                    instr_nx_s  = {INSTR_LEN{1'b0}};
                    valid_nx_s  = 1'b0;
                    halted_nx_s = 1'b1;
                end else begin
                    state_nx_s    = RUN;
                    pc_nx_s       = fetch_addr_s;
                    fetch_pc_nx_s = fetch_addr_s + STEP;
                    instr_nx_s    = rdata_s;
                    valid_nx_s    = 1'b1;
                end
            end
            HALT: begin
                state_nx_s = HALT;
            end
            default: begin
                state_nx_s  = HALT;
                instr_nx_s  = {INSTR_LEN{1'b0}};
                valid_nx_s  = 1'b0;
                halted_nx_s = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= BOOT;
            fetch_pc_r <= RESET_ADDR;
            pc_r       <= RESET_ADDR;
            instr_r    <= {INSTR_LEN{1'b0}};
            valid_r    <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            fetch_pc_r <= fetch_pc_nx_s;
            pc_r       <= pc_nx_s;
            instr_r    <= instr_nx_s;
            valid_r    <= valid_nx_s;
            halted_r   <= halted_nx_s;
        end
    end

    assign instruction_out = instr_r;
    assign pc_out          = pc_r;
    assign valid           = valid_r;
    assign halted          = halted_r;

endmodule

// File: tb/tb_i_fetch.sv
// Directed self-checking bench for i_fetch with hand-computed expectations.
module tb_i_fetch;

    localparam logic [31:0] I_LDUR = 32'hF844_02C9;
    localparam logic [31:0] I_ADD  = 32'h8B09_026A;
    localparam logic [31:0] I_SUB  = 32'hCB0A_028B;
    localparam logic [31:0] I_STUR = 32'hF806_02CB;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        uncondbranch;
    logic        branch;
    logic        zero;
    logic [63:0] branch_offset;
    logic        imem_we;
    logic [5:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] instruction_out;
    logic [63:0] pc_out;
    logic        valid;
    logic        halted;

    int test_cnt = 0;
    int fail_cnt = 0;

    i_fetch #(
        .WORD       (64),
        .INSTR_LEN  (32),
        .IMEM_DEPTH (64),
        .RESET_PC   (64'd0)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall           (stall),
        .uncondbranch    (uncondbranch),
        .branch          (branch),
        .zero            (zero),
        .branch_offset   (branch_offset),
        .imem_we         (imem_we),
        .imem_waddr      (imem_waddr),
        .imem_wdata      (imem_wdata),
        .instruction_out (instruction_out),
        .pc_out          (pc_out),
        .valid           (valid),
        .halted          (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input int i);
        case (i)
            0:       mem_word = I_LDUR;
            1:       mem_word = I_ADD;
            2:       mem_word = I_SUB;
            3:       mem_word = I_STUR;
            default: mem_word = 32'hA500_0000 + 32'(i);
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        test_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [63:0] pc, input logic [31:0] ins,
                             input logic v, input logic h);
        check_eq({tag, ".pc"}, pc_out, pc);
        check_eq({tag, ".instr"}, {32'd0, instruction_out}, {32'd0, ins});
        check_eq({tag, ".vh"}, {62'd0, valid, halted}, {62'd0, v, h});
    endtask

    initial begin
        reset_n       = 1'b1;
        stall         = 1'b0;
        uncondbranch  = 1'b0;
        branch        = 1'b0;
        zero          = 1'b0;
        branch_offset = 64'd0;
        imem_we       = 1'b0;
        imem_waddr    = 6'd0;
        imem_wdata    = 32'd0;
        #1 reset_n = 1'b0;
        #1;
        check_out("reset", 64'd0, 32'd0, 1'b0, 1'b0);
        reset_n = 1'b1;

        // Load the whole memory while the FSM free-runs to HALT.
        for (int i = 0; i < 64; i++) begin
            imem_we    = 1'b1;
            imem_waddr = 6'(i);
            imem_wdata = mem_word(i);
            tick();
        end
        imem_we = 1'b0;
        repeat (3) tick();

        // Async reset out of HALT, then sequential fetch.
        #2 reset_n = 1'b0;
        #1;
        check_out("rst_halt", 64'd0, 32'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
        tick(); check_out("seq0", 64'd0, I_LDUR, 1'b1, 1'b0);
        tick(); check_out("seq4", 64'd4, I_ADD, 1'b1, 1'b0);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check_out("stall", 64'd4, I_ADD, 1'b1, 1'b0);
        end
        stall = 1'b0;
        tick(); check_out("seq8", 64'd8, I_SUB, 1'b1, 1'b0);

        // B +8 held off by a stall cycle.
        uncondbranch = 1'b1; branch_offset = 64'd8; stall = 1'b1;
        tick(); check_out("b_stall", 64'd8, I_SUB, 1'b1, 1'b0);
        stall = 1'b0;
        tick(); check_out("b8", 64'd40, mem_word(10), 1'b1, 1'b0);
        uncondbranch = 1'b0;
        tick(); check_out("seq44", 64'd44, mem_word(11), 1'b1, 1'b0);

        uncondbranch = 1'b1; branch_offset = -64'sd3;
        tick(); check_out("b_m3", 64'd32, mem_word(8), 1'b1, 1'b0);
        uncondbranch = 1'b0; branch = 1'b1; zero = 1'b1; branch_offset = -64'sd5;
        tick(); check_out("cbz_taken", 64'd12, I_STUR, 1'b1, 1'b0);
        branch = 1'b0; uncondbranch = 1'b1; branch_offset = 64'd5;
        tick(); check_out("b_p5", 64'd32, mem_word(8), 1'b1, 1'b0);
        uncondbranch = 1'b0; branch = 1'b1; zero = 1'b0; branch_offset = -64'sd5;
        tick(); check_out("cbz_not", 64'd36, mem_word(9), 1'b1, 1'b0);
        branch = 1'b0; uncondbranch = 1'b1;
        tick(); check_out("b_16", 64'd16, mem_word(4), 1'b1, 1'b0);

        // Loader write to the word fetched on the same edge.
        uncondbranch = 1'b0;
        imem_we = 1'b1; imem_waddr = 6'd5; imem_wdata = 32'hDEAD_BEEF;
        tick(); check_out("collide", 64'd20, mem_word(5), 1'b1, 1'b0);
        imem_we = 1'b0; uncondbranch = 1'b1; branch_offset = 64'd0;
        tick(); check_out("refetch20", 64'd20, 32'hDEAD_BEEF, 1'b1, 1'b0);
        branch_offset = -64'sd5;
        tick(); check_out("b_0", 64'd0, I_LDUR, 1'b1, 1'b0);

        // B +64 from 0 lands exactly on the 256-byte boundary.
        branch_offset = 64'd64;
        tick(); check_out("oor", 64'd256, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            stall = i[0]; branch = i[1]; zero = 1'b1; uncondbranch = ~i[0];
            branch_offset = 64'(i) - 64'd3;
            tick(); check_out("frozen", 64'd256, 32'd0, 1'b0, 1'b1);
        end
        stall = 1'b0; branch = 1'b0; zero = 1'b0; uncondbranch = 1'b0;

        // Mid-cycle async reset while running; memory survives.
        reset_n = 1'b0; #1 reset_n = 1'b1;
        tick(); check_out("boot2", 64'd0, I_LDUR, 1'b1, 1'b0);
        tick();
        #3 reset_n = 1'b0;
        #1;
        check_out("rst_mid", 64'd0, 32'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
        repeat (6) tick();
        check_out("mem_kept", 64'd20, 32'hDEAD_BEEF, 1'b1, 1'b0);

        // Negative target wraps above the memory and halts.
        reset_n = 1'b0; #1 reset_n = 1'b1;
        tick();
        uncondbranch = 1'b1; branch_offset = -64'sd1;
        tick(); check_out("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 32'd0, 1'b0, 1'b1);
        uncondbranch = 1'b0;

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/i_fetch.md
Name: i_fetch

Overview:
- Instruction-fetch stage for the LEGv8 datapath. It is the producer of the instruction stream that the decode stage consumes.
- Holds the PC and a loadable instruction memory, and presents a registered instruction, PC and valid to decode.
- Redirects on B/CBZ using the decode-stage sign-extended offset and the ALU zero flag.
- Supports stall, and halts on an out-of-range fetch.

Parameters:
- WORD, 64, datapath/PC width in bits.
- INSTR_LEN, 32, instruction width in bits.
- IMEM_DEPTH, 64, instruction memory depth in words (byte span = IMEM_DEPTH*4).
- RESET_PC, 0, first fetch address after reset; must be 4-aligned.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold all fetch state this cycle.
- uncondbranch  in  1  from decode, B.
- branch  in  1  from decode, CBZ.
- zero  in  1  ALU zero flag for the instruction in instruction_out.
- branch_offset  in  WORD  sign-extended word offset from decode (sign_extended_output).
- imem_we  in  1  loader write enable.
- imem_waddr  in  $clog2(IMEM_DEPTH)  loader word address.
- imem_wdata  in  INSTR_LEN  loader write data.
- instruction_out  out  INSTR_LEN  instruction presented to decode.
- pc_out  out  WORD  byte address of instruction_out.
- valid  out  1  instruction_out is meaningful.
- halted  out  1  sticky out-of-range fetch indicator.

Behaviour:
- Reset (async assert, sync release): state=BOOT, fetch_pc=RESET_PC, pc_out=RESET_PC, instruction_out=0, valid=0, halted=0. Memory contents are not cleared.
- States: BOOT, RUN, HALT.
- BOOT (one cycle, ignores stall and redirect): register imem[RESET_PC>>2], pc_out=RESET_PC, valid=1, fetch_pc=RESET_PC+4, go to RUN. If RESET_PC is out of range, go to HALT instead.
- RUN with stall=1: instruction_out, pc_out, valid and fetch_pc all hold. The redirect inputs are ignored; decode holds them.
- RUN with stall=0:
  - pc_src = valid & (uncondbranch | (branch & zero)).
  - target = pc_out + (branch_offset << 2), computed mod 2^WORD with silent wrap.
  - next_addr = pc_src ? target : fetch_pc.
  - On the edge: instruction_out=imem[next_addr>>2], pc_out=next_addr, fetch_pc=next_addr+4, valid=1.
  - A redirect therefore has zero bubbles.
- Out of range means next_addr >= IMEM_DEPTH*4; this includes wrapped negative targets. On that edge: valid=0, instruction_out=0, halted=1, pc_out=next_addr (for debug), go to HALT.
- HALT: all outputs hold, including halted=1. Exit is via reset_n only.
- Alignment: next_addr[1:0] is always 0, because RESET_PC is aligned and targets are shifted.
- Loader:
  - imem_we writes imem_wdata to imem[imem_waddr] on the edge, in any state.
  - If the write address equals the word being fetched in the same cycle, the fetch returns the OLD word.
- Reset mid-operation: immediate return to the reset values above, regardless of stall or state. An in-flight write is dropped only if reset_n is low at that edge.

Decomposition:
- Shared package arm_pkg: WORD, INSTR_LEN, the fetch_state_t enum {BOOT, RUN, HALT}, and the opcode constants already used by decode.
- One sub-module, i_mem: IMEM_DEPTH x INSTR_LEN array with synchronous write port and combinational read port; no reset.
- i_fetch holds the FSM, PC logic and output register.

Test Plan:
- Sequential fetch:
  - Stimulus: load imem[0..3] = {LDUR X9,[X22,#64]; ADD X10,X19,X9; SUB X11,X20,X10; STUR X11,[X22,#96]}, release reset.
  - Required: BOOT cycle, then pc_out = 0, 4, 8, 12 on successive edges with the matching instruction_out; valid=1 from the first edge after reset release.
- Stall:
  - Stimulus: stall=1 for 3 cycles while pc_out=4.
  - Required: pc_out=4, instruction_out=ADD word and valid=1 held for those 3 cycles; pc_out=8 on the first edge after stall drops.
- CBZ backward:
  - Stimulus: instruction at pc_out=32, branch=1, zero=1, branch_offset=-5 (0xFFFFFFFFFFFFFFFB).
  - Required: next pc_out=12, with instruction_out=imem[3]. With zero=0 instead, next pc_out=36.
- B out of range:
  - Stimulus: at pc_out=0, uncondbranch=1, branch_offset=64.
  - Required: target 256 >= 256, so valid=0, halted=1, pc_out=256; outputs stay frozen for 10 further cycles despite stall and branch toggling.
- B 8 and redirect under stall:
  - Stimulus: at pc_out=8, uncondbranch=1, offset=8, stall=1 for 1 cycle.
  - Required: no redirect during the stall cycle; after it, pc_out=40.
- Loader collision and reset:
  - Stimulus: write imem[5]=0xDEADBEEF in the same cycle pc 20 is fetched.
  - Required: instruction_out is the old word. After the pc wraps back through 20, it reads 0xDEADBEEF.
  - Stimulus: assert reset_n=0 mid-run between clock edges.
  - Required: outputs return to their reset values immediately, without waiting for an edge.
